// File: rtl/axi_master_burst.sv
// Single-outstanding AXI4 burst master bridging a simple command/stream port.
// Optional WRAP bursts for 2/4-beat commands: define AXI_MASTER_BURST_WRAP_EN.
module axi_master_burst #(
  parameter logic [3:0] DEF_CACHE = 4'b0000,
  parameter logic [2:0] DEF_PROT  = 3'b000
) (
  input  logic         pll_core_cpuclk,
  input  logic         pad_cpu_rst_b,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [39:0]  cmd_addr,
  input  logic [7:0]   cmd_len,
  input  logic [7:0]   cmd_id,
  input  logic         cmd_wrap,
  input  logic         wd_valid,
  output logic         wd_ready,
  input  logic [127:0] wd_data,
  input  logic [15:0]  wd_strb,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [127:0] rd_data,
  output logic         rd_last,
  output logic         done_valid,
  output logic [1:0]   done_resp,
  output logic [39:0]  awaddr_m0,
  output logic [7:0]   awid_m0,
  output logic [7:0]   awlen_m0,
  output logic [2:0]   awsize_m0,
  output logic [1:0]   awburst_m0,
  output logic [3:0]   awcache_m0,
  output logic [2:0]   awprot_m0,
  output logic         awvalid_m0,
  input  logic         awready_m0,
  output logic [127:0] wdata_m0,
  output logic [15:0]  wstrb_m0,
  output logic         wlast_m0,
  output logic         wvalid_m0,
  input  logic         wready_m0,
  input  logic [7:0]   bid_m0,
  input  logic [1:0]   bresp_m0,
  input  logic         bvalid_m0,
  output logic         bready_m0,
  output logic [39:0]  araddr_m0,
  output logic [7:0]   arid_m0,
  output logic [7:0]   arlen_m0,
  output logic [2:0]   arsize_m0,
  output logic [1:0]   arburst_m0,
  output logic [3:0]   arcache_m0,
  output logic [2:0]   arprot_m0,
  output logic         arvalid_m0,
  input  logic         arready_m0,
  input  logic [127:0] rdata_m0,
  input  logic [7:0]   rid_m0,
  input  logic [1:0]   rresp_m0,
  input  logic         rlast_m0,
  input  logic         rvalid_m0,
  output logic         rready_m0
);

  typedef enum logic [2:0] {
    IDLE, AR, RDATA, AW, WDATA, BRESP
  } state_t;

  state_t      state_q, state_d;
  logic [39:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  id_q;
  logic        write_q;
  logic [1:0]  burst_q;
  logic [7:0]  cnt_q;
  logic [1:0]  resp_q;
  logic        id_err_q;
  logic        done_valid_q;
  logic [1:0]  done_resp_q;

  logic        cmd_hs, ar_hs, aw_hs;
  logic        w_hs, r_hs, b_hs;
  logic        last_beat, final_hs;
  logic [1:0]  burst_cmd;
  logic [1:0]  beat_resp, resp_d;
  logic [7:0]  beat_id;
  logic        err_d;
  logic        unused_ok;

  // termination is by beat count; rlast and the low address nibble are unused
  assign unused_ok = ^{cmd_addr[3:0], cmd_wrap, rlast_m0};

`ifdef AXI_MASTER_BURST_WRAP_EN
  assign burst_cmd =
    (cmd_wrap && (cmd_len == 8'd1 || cmd_len == 8'd3))
    ? 2'b10 : 2'b01;
`else
  assign burst_cmd = 2'b01;
`endif

  assign cmd_hs    = cmd_valid & cmd_ready;
  assign ar_hs     = (state_q == AR) & arready_m0;
  assign aw_hs     = (state_q == AW) & awready_m0;
  assign w_hs      = (state_q == WDATA) & wd_valid & wready_m0;
  assign r_hs      = (state_q == RDATA) & rvalid_m0 & rd_ready;
  assign b_hs      = (state_q == BRESP) & bvalid_m0;
  assign last_beat = (cnt_q == len_q);
  assign final_hs  = (r_hs & last_beat) | b_hs;

  // first non-OKAY response sticks; any ID mismatch overrides to SLVERR
  assign beat_resp = write_q ? bresp_m0 : rresp_m0;
  assign beat_id   = write_q ? bid_m0 : rid_m0;
  assign resp_d    = (resp_q == 2'b00) ? beat_resp : resp_q;
  assign err_d     = id_err_q | (beat_id != id_q);

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cmd_hs) state_d = cmd_write ? AW : AR;
      AR:    if (ar_hs) state_d = RDATA;
      RDATA: if (r_hs && last_beat) state_d = IDLE;
      AW:    if (aw_hs) state_d = WDATA;
      WDATA: if (w_hs && last_beat) state_d = BRESP;
      BRESP: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    arvalid_m0 = 1'b0;
    awvalid_m0 = 1'b0;
    wvalid_m0  = 1'b0;
    wd_ready   = 1'b0;
    wlast_m0   = 1'b0;
    bready_m0  = 1'b0;
    rready_m0  = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    unique case (state_q)
      IDLE:  cmd_ready = pad_cpu_rst_b;
      AR:    arvalid_m0 = 1'b1;
      AW:    awvalid_m0 = 1'b1;
      WDATA: begin
        wvalid_m0 = wd_valid;
        wd_ready  = wready_m0;
        wlast_m0  = last_beat;
      end
      BRESP: bready_m0 = 1'b1;
      RDATA: begin
        rd_valid  = rvalid_m0;
        rready_m0 = rd_ready;
        rd_last   = last_beat & rvalid_m0;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      addr_q       <= '0;
      len_q        <= '0;
      id_q         <= '0;
      write_q      <= 1'b0;
      burst_q      <= 2'b01;
      cnt_q        <= '0;
      resp_q       <= '0;
      id_err_q     <= 1'b0;
      done_valid_q <= 1'b0;
      done_resp_q  <= '0;
    end else begin
      done_valid_q <= final_hs;
      if (final_hs)
        done_resp_q <= err_d ? 2'b10 : resp_d;
      if (cmd_hs) begin
        addr_q   <= {cmd_addr[39:4], 4'h0};
        len_q    <= cmd_len;
        id_q     <= cmd_id;
        write_q  <= cmd_write;
        burst_q  <= burst_cmd;
        cnt_q    <= '0;
        resp_q   <= '0;
        id_err_q <= 1'b0;
      end
      if (ar_hs || aw_hs)
        cnt_q <= '0;
      else if (w_hs || r_hs)
        cnt_q <= cnt_q + 8'd1;
      if (r_hs || b_hs) begin
        resp_q   <= resp_d;
        id_err_q <= err_d;
      end
    end
  end

  assign done_valid = done_valid_q;
  assign done_resp  = done_resp_q;

  assign awaddr_m0  = addr_q;
  assign awid_m0    = id_q;
  assign awlen_m0   = len_q;
  assign awsize_m0  = 3'b100;
  assign awburst_m0 = burst_q;
  assign awcache_m0 = DEF_CACHE;
  assign awprot_m0  = DEF_PROT;

  assign araddr_m0  = addr_q;
  assign arid_m0    = id_q;
  assign arlen_m0   = len_q;
  assign arsize_m0  = 3'b100;
  assign arburst_m0 = burst_q;
  assign arcache_m0 = DEF_CACHE;
  assign arprot_m0  = DEF_PROT;

  assign wdata_m0 = wd_data;
  assign wstrb_m0 = wd_strb;
  assign rd_data  = rdata_m0;

endmodule

// File: tb/tb_axi_master_burst.sv
// Bench for axi_master_burst: vector table plus scoreboard queues,
// with an AXI slave model and a mid-burst reset sequence.
module tb_axi_master_burst;

  localparam logic [3:0] CACHE = 4'b0011;
  localparam logic [2:0] PROT  = 3'b010;
`ifdef AXI_MASTER_BURST_WRAP_EN
  localparam logic [1:0] WRAPB = 2'b10;
`else
  localparam logic [1:0] WRAPB = 2'b01;
`endif

  logic clk, rst_b;
  logic cmd_valid, cmd_ready, cmd_write, cmd_wrap;
  logic [39:0] cmd_addr;
  logic [7:0] cmd_len, cmd_id;
  logic wd_valid, wd_ready;
  logic [127:0] wd_data;
  logic [15:0] wd_strb;
  logic rd_valid, rd_ready, rd_last;
  logic [127:0] rd_data;
  logic done_valid;
  logic [1:0] done_resp;
  logic [39:0] awaddr_m0, araddr_m0;
  logic [7:0] awid_m0, awlen_m0, arid_m0, arlen_m0;
  logic [2:0] awsize_m0, awprot_m0, arsize_m0, arprot_m0;
  logic [1:0] awburst_m0, arburst_m0;
  logic [3:0] awcache_m0, arcache_m0;
  logic awvalid_m0, awready_m0, arvalid_m0, arready_m0;
  logic [127:0] wdata_m0, rdata_m0;
  logic [15:0] wstrb_m0;
  logic wlast_m0, wvalid_m0, wready_m0;
  logic [7:0] bid_m0, rid_m0;
  logic [1:0] bresp_m0, rresp_m0;
  logic bvalid_m0, bready_m0;
  logic rlast_m0, rvalid_m0, rready_m0;

  axi_master_burst #(.DEF_CACHE(CACHE), .DEF_PROT(PROT)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_wrap(cmd_wrap),
    .wd_valid(wd_valid), .wd_ready(wd_ready),
    .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_resp(done_resp),
    .awaddr_m0(awaddr_m0), .awid_m0(awid_m0), .awlen_m0(awlen_m0),
    .awsize_m0(awsize_m0), .awburst_m0(awburst_m0),
    .awcache_m0(awcache_m0), .awprot_m0(awprot_m0),
    .awvalid_m0(awvalid_m0), .awready_m0(awready_m0),
    .wdata_m0(wdata_m0), .wstrb_m0(wstrb_m0), .wlast_m0(wlast_m0),
    .wvalid_m0(wvalid_m0), .wready_m0(wready_m0),
    .bid_m0(bid_m0), .bresp_m0(bresp_m0),
    .bvalid_m0(bvalid_m0), .bready_m0(bready_m0),
    .araddr_m0(araddr_m0), .arid_m0(arid_m0), .arlen_m0(arlen_m0),
    .arsize_m0(arsize_m0), .arburst_m0(arburst_m0),
    .arcache_m0(arcache_m0), .arprot_m0(arprot_m0),
    .arvalid_m0(arvalid_m0), .arready_m0(arready_m0),
    .rdata_m0(rdata_m0), .rid_m0(rid_m0), .rresp_m0(rresp_m0),
    .rlast_m0(rlast_m0), .rvalid_m0(rvalid_m0), .rready_m0(rready_m0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit wr; logic [39:0] addr; logic [7:0] len; logic [7:0] id;
    bit wrap; int dly; bit tog; int eb; logic [1:0] er; bit bad;
    logic [1:0] xburst; logic [1:0] xresp;
  } vec_t;

  typedef struct {
    logic [39:0] addr; logic [7:0] len; logic [7:0] id;
    logic [1:0] burst;
  } cmd_exp_t;

  typedef struct {
    logic [127:0] d; logic [15:0] s; bit last;
  } beat_t;

  cmd_exp_t   cmd_q[$];
  beat_t      data_q[$];
  logic [1:0] resp_q[$];
  vec_t       tv[12];

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done_valid === 1'b1) done_cnt++;

  task automatic check(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no handshake expected one within budget", nm);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $fatal(1, "bench aborted on timeout");
  endtask

  function automatic vec_t mk(bit wr, logic [39:0] a, logic [7:0] l,
      logic [7:0] id, bit wrap, int dly, bit tog, int eb,
      logic [1:0] er, bit bad, logic [1:0] xb, logic [1:0] xr);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = l; v.id = id; v.wrap = wrap;
    v.dly = dly; v.tog = tog; v.eb = eb; v.er = er; v.bad = bad;
    v.xburst = xb; v.xresp = xr;
    return v;
  endfunction

  task automatic do_cmd(input vec_t v);
    int cyc;
    cmd_exp_t ce;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_len = v.len; cmd_id = v.id; cmd_wrap = v.wrap;
    ce.addr = {v.addr[39:4], 4'h0};
    ce.len = v.len; ce.id = v.id; ce.burst = v.xburst;
    cmd_q.push_back(ce);
    resp_q.push_back(v.xresp);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++cyc > 40) tmo("cmd_ready");
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic do_addr(input vec_t v);
    int cyc;
    cmd_exp_t ce;
    ce = cmd_q.pop_front();
    cyc = 0;
    forever begin
      if (cyc >= v.dly) begin
        if (v.wr) awready_m0 = 1; else arready_m0 = 1;
      end
      @(negedge clk);
      if (v.wr) begin
        check("awvalid", awvalid_m0, 1);
        check("arvalid_off", arvalid_m0, 0);
        check("awaddr", awaddr_m0, ce.addr);
        check("awlen", awlen_m0, ce.len);
        check("awid", awid_m0, ce.id);
        check("awburst", awburst_m0, ce.burst);
        check("awattr", {awsize_m0, awcache_m0, awprot_m0},
              {3'b100, CACHE, PROT});
      end else begin
        check("arvalid", arvalid_m0, 1);
        check("awvalid_off", awvalid_m0, 0);
        check("araddr", araddr_m0, ce.addr);
        check("arlen", arlen_m0, ce.len);
        check("arid", arid_m0, ce.id);
        check("arburst", arburst_m0, ce.burst);
        check("arattr", {arsize_m0, arcache_m0, arprot_m0},
              {3'b100, CACHE, PROT});
      end
      if (v.wr ? awready_m0 : arready_m0) break;
      if (++cyc > 40) tmo("addr_ready");
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    awready_m0 = 0;
    arready_m0 = 0;
  endtask

  task automatic chk_done();
    logic [1:0] r;
    r = resp_q.pop_front();
    @(negedge clk);
    check("done_valid", done_valid, 1);
    check("done_resp", done_resp, r);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_pulse_end", done_valid, 0);
    check("cmd_ready_idle", cmd_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    beat_t be;
    do_cmd(v);
    do_addr(v);
    if (v.wr) begin
      for (int b = 0; b <= int'(v.len); b++) begin
        be.d = {$urandom, $urandom, $urandom, $urandom};
        be.s = 16'($urandom);
        be.last = (b == int'(v.len));
        wd_valid = 1; wd_data = be.d; wd_strb = be.s;
        data_q.push_back(be);
        cyc = 0;
        forever begin
          wready_m0 = v.tog ? (cyc % 2 == 1) : 1'b1;
          @(negedge clk);
          if (wvalid_m0 && wready_m0) begin
            be = data_q.pop_front();
            check("wdata", wdata_m0, be.d);
            check("wstrb", wstrb_m0, be.s);
            check("wlast", wlast_m0, be.last);
            check("wd_ready", wd_ready, 1);
            break;
          end
          if (++cyc > 40) tmo("w_beat");
          @(posedge clk); #1;
        end
        @(posedge clk); #1;
      end
      wd_valid = 0; wready_m0 = 0;
      bvalid_m0 = 1;
      bid_m0 = v.bad ? (v.id ^ 8'h5a) : v.id;
      bresp_m0 = (v.eb >= 0) ? v.er : 2'b00;
      cyc = 0;
      forever begin
        @(negedge clk);
        if (bready_m0) break;
        if (++cyc > 40) tmo("bready");
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bvalid_m0 = 0;
    end else begin
      for (int b = 0; b <= int'(v.len); b++) begin
        be.d = {$urandom, $urandom, $urandom, $urandom};
        be.s = '0;
        be.last = (b == int'(v.len));
        rvalid_m0 = 1; rdata_m0 = be.d; rlast_m0 = be.last;
        rid_m0 = (v.bad && b == 0) ? (v.id ^ 8'h5a) : v.id;
        rresp_m0 = (b == v.eb) ? v.er :
                   (v.eb >= 0 && b > v.eb) ? 2'b10 : 2'b00;
        data_q.push_back(be);
        cyc = 0;
        forever begin
          rd_ready = v.tog ? (cyc % 2 == 1) : 1'b1;
          @(negedge clk);
          if (rd_valid && rd_ready) begin
            be = data_q.pop_front();
            check("rd_data", rd_data, be.d);
            check("rd_last", rd_last, be.last);
            check("rready_m0", rready_m0, 1);
            break;
          end
          if (++cyc > 40) tmo("r_beat");
          @(posedge clk); #1;
        end
        @(posedge clk); #1;
      end
      rvalid_m0 = 0; rd_ready = 0;
    end
    chk_done();
  endtask

  initial begin
    vec_t v;
    int dsnap;
    rst_b = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    cmd_id = '0; cmd_wrap = 0;
    wd_valid = 0; wd_data = '0; wd_strb = '0; rd_ready = 0;
    awready_m0 = 0; arready_m0 = 0; wready_m0 = 0;
    bid_m0 = '0; bresp_m0 = '0; bvalid_m0 = 0;
    rdata_m0 = '0; rid_m0 = '0; rresp_m0 = '0;
    rlast_m0 = 0; rvalid_m0 = 0;

    //           wr addr             len  id  wrp dly tog eb er  bad burst  resp
    tv[0]  = mk(1, 40'h1000,        3, 8'h05, 0, 0, 0, -1, 0, 0, 2'b01, 2'b00);
    tv[1]  = mk(0, 40'h2000,        0, 8'h11, 0, 3, 0, -1, 0, 0, 2'b01, 2'b00);
    tv[2]  = mk(0, 40'h3000,        7, 8'h22, 0, 0, 1, -1, 0, 0, 2'b01, 2'b00);
    tv[3]  = mk(0, 40'h4000,        3, 8'h33, 0, 1, 0, 1, 2'b10, 0, 2'b01, 2'b10);
    tv[4]  = mk(1, 40'h5000,        1, 8'h44, 0, 0, 0, -1, 0, 1, 2'b01, 2'b10);
    tv[5]  = mk(0, 40'h30,          3, 8'h55, 1, 0, 0, -1, 0, 0, WRAPB, 2'b00);
    tv[6]  = mk(1, 40'h6008,        0, 8'h66, 0, 2, 1, -1, 0, 0, 2'b01, 2'b00);
    tv[7]  = mk(0, 40'h7000,        2, 8'h77, 0, 0, 0, 0, 2'b01, 0, 2'b01, 2'b01);
    tv[8]  = mk(1, 40'h8000,        2, 8'h88, 0, 0, 0, 0, 2'b11, 0, 2'b01, 2'b11);
    tv[9]  = mk(0, 40'h9000,        1, 8'h99, 0, 0, 0, -1, 0, 1, 2'b01, 2'b10);
    tv[10] = mk(0, 40'h34,          2, 8'haa, 1, 0, 1, -1, 0, 0, 2'b01, 2'b00);
    tv[11] = mk(1, 40'hff_ffff_fff0, 15, 8'hff, 0, 1, 1, -1, 0, 0, 2'b01, 2'b00);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valids",
          {cmd_ready, awvalid_m0, arvalid_m0, wvalid_m0, wd_ready,
           bready_m0, rready_m0, rd_valid, wlast_m0, rd_last}, 0);
    check("rst_fields", {awaddr_m0, awlen_m0, awid_m0, araddr_m0}, 0);
    check("rst_done", {done_valid, done_resp}, 0);
    @(posedge clk); #1;
    rst_b = 1;
    @(negedge clk);
    check("cmd_ready_release", cmd_ready, 1);

    for (int i = 0; i < 12; i++) run_vec(tv[i]);

    // reset during the second write beat
    v = mk(1, 40'ha000, 3, 8'ha5, 0, 0, 0, -1, 0, 0, 2'b01, 2'b00);
    do_cmd(v);
    do_addr(v);
    wd_valid = 1; wd_data = 128'h1; wd_strb = 16'hffff; wready_m0 = 1;
    @(negedge clk);
    check("rst_beat1_hs", {wvalid_m0, wd_ready, wlast_m0}, 3'b110);
    @(posedge clk); #1;
    wd_data = 128'h2;
    #2 rst_b = 0;
    #1;
    check("midrst_valids",
          {cmd_ready, awvalid_m0, arvalid_m0, wvalid_m0, wd_ready,
           bready_m0, rready_m0, rd_valid, wlast_m0, done_valid}, 0);
    dsnap = done_cnt;
    resp_q.delete();
    @(posedge clk); #1;
    wd_valid = 0; wready_m0 = 0;
    rst_b = 1;
    @(negedge clk);
    check("midrst_idle", cmd_ready, 1);
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt, dsnap);

    run_vec(tv[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
